// File: rtl/period_meter.sv
// Period meter: measures sig_in period in clk_1k ticks, averages 2**AVG_LOG2
// accepted periods and flags loss of signal after MAX_PERIOD idle ticks.
//
//  state | meaning
//  ARM   | waiting for the first rising edge to start timing
//  MEAS  | timing edge-to-edge, accumulating accepted periods
module period_meter #(
  parameter int MIN_PERIOD = 2,
  parameter int MAX_PERIOD = 1000,
  parameter int AVG_LOG2   = 2
) (
  input  logic        clk_1k,
  input  logic        rst,
  input  logic        sig_in,
  output logic [15:0] period,
  output logic        period_vld,
  output logic        timeout
);

  localparam int AW = 16 + AVG_LOG2;
  localparam int NW = AVG_LOG2 + 1;
  localparam logic [NW-1:0] NLAST = NW'((1 << AVG_LOG2) - 1);
  localparam logic [15:0]   MINP  = 16'(MIN_PERIOD);
  localparam logic [15:0]   MAXP  = 16'(MAX_PERIOD);

  typedef enum logic {ARM, MEAS} state_t;

  state_t          state, state_nxt;
  logic            s1, s2, s3;
  logic            rise;
  logic [15:0]     cnt, cnt_nxt;
  logic [AW-1:0]   acc, acc_nxt, sum;
  logic [NW-1:0]   nacc, nacc_nxt;
  logic [15:0]     period_nxt;
  logic            vld_nxt, timeout_nxt;

  assign rise = s2 & ~s3;
  assign sum  = acc + AW'(cnt);

  // s1/s2 resynchronise sig_in; s3 delays s2 for edge detection
  always_ff @(posedge clk_1k or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk_1k or negedge rst) begin
    if (!rst) begin
      state      <= ARM;
      cnt        <= '0;
      acc        <= '0;
      nacc       <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      acc        <= acc_nxt;
      nacc       <= nacc_nxt;
      period     <= period_nxt;
      period_vld <= vld_nxt;
      timeout    <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    acc_nxt     = acc;
    nacc_nxt    = nacc;
    period_nxt  = period;
    vld_nxt     = 1'b0;
    timeout_nxt = timeout;
    case (state)
      ARM: begin
        if (rise) begin
          cnt_nxt   = 16'd1;
          acc_nxt   = '0;
          nacc_nxt  = '0;
          state_nxt = MEAS;
        end
      end
      MEAS: begin
        // an accepted edge takes priority over the terminal count
        if (rise && cnt >= MINP) begin
          acc_nxt  = sum;
          nacc_nxt = nacc + NW'(1);
          cnt_nxt  = 16'd1;
          if (nacc == NLAST) begin
            period_nxt  = 16'(sum >> AVG_LOG2);
            vld_nxt     = 1'b1;
            timeout_nxt = 1'b0;
            acc_nxt     = '0;
            nacc_nxt    = '0;
          end
        end else if (cnt == MAXP) begin
          period_nxt  = '0;
          vld_nxt     = 1'b1;
          timeout_nxt = 1'b1;
          cnt_nxt     = '0;
          acc_nxt     = '0;
          nacc_nxt    = '0;
          state_nxt   = ARM;
        end else if (cnt != 16'hFFFF) begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      default: state_nxt = ARM;
    endcase
  end

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: two instances (averaging and non-averaging) on one
// stimulus, checked against an edge-level reference model and a vector table.
module tb_period_meter;

  localparam int MAX = 1000;
  localparam int LAT = 3;

  typedef struct {
    int k;
    int t;
    int per;
    int to;
  } ev_t;

  typedef struct {
    int p0;
    int p1;
    int p2;
    int p3;
    int exp_per;
  } seg_t;

  logic        clk_1k = 1'b0;
  logic        rst;
  logic        sig_in;
  logic [15:0] period_a, period_b;
  logic        vld_a, vld_b, timeout_a, timeout_b;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  ev_t exp_q[$];
  ev_t act_q[$];

  int mmin[2]   = '{2, 5};
  int ml[2]     = '{2, 0};
  int marmed[2] = '{0, 0};
  int mlast[2]  = '{0, 0};
  int msum[2]   = '{0, 0};
  int mn[2]     = '{0, 0};
  int mper[2]   = '{0, 0};
  int mto[2]    = '{0, 0};

  seg_t tbl[7];

  period_meter #(.MIN_PERIOD(2), .MAX_PERIOD(MAX), .AVG_LOG2(2)) dut_a (
    .clk_1k(clk_1k), .rst(rst), .sig_in(sig_in),
    .period(period_a), .period_vld(vld_a), .timeout(timeout_a)
  );

  period_meter #(.MIN_PERIOD(5), .MAX_PERIOD(MAX), .AVG_LOG2(0)) dut_b (
    .clk_1k(clk_1k), .rst(rst), .sig_in(sig_in),
    .period(period_b), .period_vld(vld_b), .timeout(timeout_b)
  );

  always #5 clk_1k = ~clk_1k;

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish want finish within 80000 cycles");
    $fatal(1);
  end

  task automatic check_int(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic model_push(input int k, input int t, input int per, input int to);
    exp_q.push_back('{k: k, t: t, per: per, to: to});
    mper[k] = per;
    mto[k]  = to;
  endtask

  // Timeout fires MAX ticks after the last accepted edge unless an edge comes first.
  task automatic model_flush(input int k, input int now);
    if (marmed[k] != 0 && mlast[k] + MAX + LAT <= now) begin
      model_push(k, mlast[k] + MAX + LAT, 0, 1);
      marmed[k] = 0;
    end
  endtask

  task automatic model_rise(input int k, input int t);
    int avg;
    if (marmed[k] != 0 && t - mlast[k] > MAX) begin
      model_push(k, mlast[k] + MAX + LAT, 0, 1);
      marmed[k] = 0;
    end
    if (marmed[k] == 0) begin
      marmed[k] = 1;
      mlast[k]  = t;
      msum[k]   = 0;
      mn[k]     = 0;
    end else if (t - mlast[k] >= mmin[k]) begin
      msum[k] += t - mlast[k];
      mn[k]++;
      mlast[k] = t;
      if (mn[k] == (1 << ml[k])) begin
        avg = msum[k] >> ml[k];
        model_push(k, t + LAT, avg, 0);
        msum[k] = 0;
        mn[k]   = 0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk_1k);
    cyc++;
    if (vld_a) act_q.push_back('{k: 0, t: cyc, per: int'(period_a), to: int'(timeout_a)});
    if (vld_b) act_q.push_back('{k: 1, t: cyc, per: int'(period_b), to: int'(timeout_b)});
  endtask

  task automatic drive_level(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (v && !sig_in) begin
        model_rise(0, cyc);
        model_rise(1, cyc);
      end
      sig_in = v;
    end
  endtask

  task automatic drive_period(input int p);
    drive_level(1'b1, p / 2);
    drive_level(1'b0, p - p / 2);
  endtask

  task automatic final_rise();
    drive_level(1'b1, 2);
    drive_level(1'b0, 3);
  endtask

  task automatic do_reset(input string tag);
    drive_level(1'b0, 4);
    model_flush(0, cyc);
    model_flush(1, cyc);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      marmed[k] = 0;
      msum[k]   = 0;
      mn[k]     = 0;
      mper[k]   = 0;
      mto[k]    = 0;
    end
    step();
    check_int({tag, " rst period_a"}, int'(period_a), 0);
    check_int({tag, " rst vld_a"}, int'(vld_a), 0);
    check_int({tag, " rst timeout_a"}, int'(timeout_a), 0);
    check_int({tag, " rst period_b"}, int'(period_b), 0);
    step();
    rst = 1'b1;
  endtask

  task automatic check_point(input string tag);
    ev_t e[$];
    ev_t a[$];
    model_flush(0, cyc);
    model_flush(1, cyc);
    for (int k = 0; k < 2; k++) begin
      e.delete();
      a.delete();
      foreach (exp_q[i]) if (exp_q[i].k == k) e.push_back(exp_q[i]);
      foreach (act_q[i]) if (act_q[i].k == k) a.push_back(act_q[i]);
      check_int($sformatf("%s k%0d vld count", tag, k), a.size(), e.size());
      for (int i = 0; i < e.size() && i < a.size(); i++) begin
        tests++;
        if (a[i].t != e[i].t || a[i].per != e[i].per || a[i].to != e[i].to) begin
          fails++;
          $display("FAIL %s k%0d ev%0d: got t=%0d period=%0d timeout=%0d want t=%0d period=%0d timeout=%0d",
                   tag, k, i, a[i].t, a[i].per, a[i].to, e[i].t, e[i].per, e[i].to);
        end
      end
      check_int($sformatf("%s k%0d period level", tag, k),
                (k == 0) ? int'(period_a) : int'(period_b), mper[k]);
      check_int($sformatf("%s k%0d timeout level", tag, k),
                (k == 0) ? int'(timeout_a) : int'(timeout_b), mto[k]);
    end
    exp_q.delete();
    act_q.delete();
  endtask

  initial begin
    int r;
    tbl[0] = '{8, 12, 8, 12, 10};
    tbl[1] = '{9, 9, 9, 10, 9};
    tbl[2] = '{50, 50, 50, 50, 50};
    tbl[3] = '{25, 25, 25, 25, 25};
    tbl[4] = '{1000, 1000, 1000, 1000, 1000};
    tbl[5] = '{2, 3, 2, 3, 2};
    tbl[6] = '{7, 7, 7, 8, 7};

    rst    = 1'b0;
    sig_in = 1'b0;
    step();
    step();
    check_int("reset period_a", int'(period_a), 0);
    check_int("reset vld_a", int'(vld_a), 0);
    check_int("reset timeout_a", int'(timeout_a), 0);
    check_int("reset vld_b", int'(vld_b), 0);
    rst = 1'b1;
    drive_level(1'b0, 3);

    // non-averaging instance tracks a steady 10-tick signal
    for (int i = 0; i < 6; i++) drive_period(10);
    check_int("avg0 period_b", int'(period_b), 10);
    check_int("avg0 timeout_b", int'(timeout_b), 0);
    check_point("avg0");

    // short pulse 3 ticks after an edge is below MIN_PERIOD=5 of dut_b
    do_reset("glitch");
    drive_level(1'b1, 2);
    drive_level(1'b0, 1);
    drive_level(1'b1, 1);
    drive_level(1'b0, 16);
    final_rise();
    check_int("glitch period_b", int'(period_b), 20);
    check_point("glitch");

    // reset with two samples already accumulated must discard them
    do_reset("pre");
    for (int i = 0; i < 3; i++) drive_period(10);
    do_reset("mid");
    for (int i = 0; i < 4; i++) drive_period(15);
    final_rise();
    check_int("mid period_a", int'(period_a), 15);
    check_int("mid timeout_a", int'(timeout_a), 0);
    check_point("mid");

    do_reset("tbl");
    for (int e = 0; e < 7; e++) begin
      drive_period(tbl[e].p0);
      drive_period(tbl[e].p1);
      drive_period(tbl[e].p2);
      drive_period(tbl[e].p3);
      final_rise();
      check_int($sformatf("tbl%0d period_a", e), int'(period_a), tbl[e].exp_per);
      check_int($sformatf("tbl%0d timeout_a", e), int'(timeout_a), 0);
      drive_level(1'b0, 1010);
      check_int($sformatf("tbl%0d lost period_a", e), int'(period_a), 0);
      check_int($sformatf("tbl%0d lost timeout_a", e), int'(timeout_a), 1);
      check_point($sformatf("tbl%0d", e));
    end

    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4)       drive_period($urandom_range(998, 1002));
      else if (r < 7)  drive_period($urandom_range(1003, 1100));
      else if (r < 17) drive_period($urandom_range(2, 5));
      else             drive_period($urandom_range(6, 40));
    end
    drive_level(1'b0, 1100);
    check_point("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
